// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: request, response and multiplier-array signals of mult_share_ctrl.
// slave is the controller side; master is the front end / array / consumer side.
interface mult_share_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    // requester 0
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_m;
    logic [WIDTH-1:0]   req0_q;

    // requester 1
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_m;
    logic [WIDTH-1:0]   req1_q;

    // shared combinational array multiplier
    logic [WIDTH-1:0]   mul_m;
    logic [WIDTH-1:0]   mul_q;
    logic [2*WIDTH-1:0] mul_p;

    // tagged response channel
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_id;

    modport slave (
        input  req0_valid, req0_m, req0_q,
        input  req1_valid, req1_m, req1_q,
        input  mul_p,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output mul_m, mul_q,
        output rsp_valid, rsp_result, rsp_id
    );

    modport master (
        output req0_valid, req0_m, req0_q,
        output req1_valid, req1_m, req1_q,
        output mul_p,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  mul_m, mul_q,
        input  rsp_valid, rsp_result, rsp_id
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: arbitrates two requesters onto one combinational array multiplier,
// holds the registered operands for a settle window (multicycle path), captures the
// product and returns it on a tagged valid/ready response channel.
// Build option MULT_SHARE_RR_EN: round-robin grant on contention; when undefined,
// requester 0 has fixed priority.
module mult_share_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    mult_share_ctrl_if.slave        bus,
    output logic                    busy,
    output logic [15:0]             op_count
);

    localparam int unsigned PW         = 2 * WIDTH;
    localparam int unsigned CNT_W      = 4;
    // 0 behaves as 1; values beyond the counter range saturate at 15
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               last_grant;
    logic [WIDTH-1:0]   mul_m_r;
    logic [WIDTH-1:0]   mul_q_r;
    logic [PW-1:0]      result_r;
    logic               rsp_id_r;
    logic               rsp_valid_r;

    logic               grant_c;
    logic               accept_c;
    logic               capture_c;
    logic               take_c;

    // Arbitration: which requester would win if a request is accepted this cycle
    always_comb begin
        grant_c = 1'b0;
`ifdef MULT_SHARE_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = ~last_grant;
        end else begin
            grant_c = bus.req1_valid;
        end
`else
        grant_c = ~bus.req0_valid & bus.req1_valid;
`endif
    end

`ifndef MULT_SHARE_RR_EN
    // last_grant is still tracked in the fixed-priority build but does not steer the grant
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        take_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture_c = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    take_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand launch, settle counter, product capture and completion count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mul_m_r     <= '0;
            mul_q_r     <= '0;
            result_r    <= '0;
            rsp_id_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy        <= 1'b0;
            op_count    <= 16'd0;
            cnt         <= '0;
            last_grant  <= 1'b1;
        end else begin
            if (accept_c) begin
                mul_m_r    <= grant_c ? bus.req1_m : bus.req0_m;
                mul_q_r    <= grant_c ? bus.req1_q : bus.req0_q;
                rsp_id_r   <= grant_c;
                last_grant <= grant_c;
                cnt        <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture_c) begin
                result_r <= bus.mul_p;
            end
            if (take_c) begin
                op_count <= op_count + 16'd1;
            end
            rsp_valid_r <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);
        end
    end

    // Ready is combinational and only ever offered to the winner in IDLE
    assign bus.req0_ready = accept_c & ~grant_c;
    assign bus.req1_ready = accept_c &  grant_c;

    assign bus.mul_m      = mul_m_r;
    assign bus.mul_q      = mul_q_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = result_r;
    assign bus.rsp_id     = rsp_id_r;

`ifndef SYNTHESIS
    // Never accept from both requesters in the same cycle
    a_one_grant: assert property (@(posedge clock) disable iff (!resetn)
        !(bus.req0_ready && bus.req1_ready));

    // A stalled response keeps its payload
    a_rsp_stable: assert property (@(posedge clock) disable iff (!resetn)
        (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_result) && $stable(bus.rsp_id)));
`endif

endmodule
